// File: rtl/image_loader.sv
// Write-side feeder for the image memory: unpacks two pixels from each accepted
// stream word and writes them to consecutive addresses, then flags completion.
module image_loader #(
    parameter int numPixels       = 784,
    parameter int addressWidthImg = 10,
    parameter int dataWidthImg    = 16,
    parameter int busWidth        = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       abort,
    input  logic                       s_valid,
    input  logic [busWidth-1:0]        s_data,
    output logic                       s_ready,
    output logic                       wen,
    output logic [addressWidthImg-1:0] wadd,
    output logic [dataWidthImg-1:0]    wdata,
    output logic                       busy,
    output logic                       done,
    output logic [addressWidthImg:0]   pix_count
);

    typedef enum logic [2:0] {
        IDLE,
        RECV,
        WR_LO,
        WR_HI,
        DONE
    } state_t;

    localparam logic [addressWidthImg:0] NUM_PIX = (addressWidthImg + 1)'(numPixels);

    state_t                   state;
    logic [dataWidthImg-1:0]  word_hi;
    logic [addressWidthImg:0] pix_inc;
    logic                     last_pix;

    // The low half goes straight to wdata at the accept edge, so only the
    // high half needs to be held for the WR_HI cycle.
    assign pix_inc  = pix_count + 1'b1;
    assign last_pix = (pix_inc == NUM_PIX);
    assign s_ready  = (state == RECV);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            word_hi   <= '0;
            wen       <= 1'b0;
            wadd      <= '0;
            wdata     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pix_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= RECV;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        pix_count <= '0;
                    end
                end

                RECV: begin
                    if (abort) begin
                        state     <= IDLE;
                        wen       <= 1'b0;
                        busy      <= 1'b0;
                        done      <= 1'b0;
                        pix_count <= '0;
                    end else if (s_valid) begin
                        state   <= WR_LO;
                        word_hi <= s_data[busWidth-1:dataWidthImg];
                        wen     <= 1'b1;
                        wadd    <= pix_count[addressWidthImg-1:0];
                        wdata   <= s_data[dataWidthImg-1:0];
                    end
                end

                WR_LO: begin
                    if (abort) begin
                        state     <= IDLE;
                        wen       <= 1'b0;
                        busy      <= 1'b0;
                        done      <= 1'b0;
                        pix_count <= '0;
                    end else begin
                        pix_count <= pix_inc;
                        if (last_pix) begin
                            // Odd image size: the high half of the final word is dropped.
                            state <= DONE;
                            wen   <= 1'b0;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state <= WR_HI;
                            wen   <= 1'b1;
                            wadd  <= pix_inc[addressWidthImg-1:0];
                            wdata <= word_hi;
                        end
                    end
                end

                WR_HI: begin
                    if (abort) begin
                        state     <= IDLE;
                        wen       <= 1'b0;
                        busy      <= 1'b0;
                        done      <= 1'b0;
                        pix_count <= '0;
                    end else begin
                        pix_count <= pix_inc;
                        wen       <= 1'b0;
                        if (last_pix) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state <= RECV;
                        end
                    end
                end

                DONE: begin
                    if (start) begin
                        state     <= RECV;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        pix_count <= '0;
                    end
                end

                default: begin
                    state <= IDLE;
                    wen   <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_image_loader.sv
// Randomized bench for image_loader: a pixel-stream queue model predicts every
// memory write, handshake, busy/done flag and pixel count cycle by cycle.
module tb_image_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic        s_valid;
    logic [31:0] s_data;

    logic        readyA, wenA, busyA, doneA;
    logic [9:0]  waddA;
    logic [15:0] wdataA;
    logic [10:0] countA;
    logic        readyB, wenB, busyB, doneB;
    logic [9:0]  waddB;
    logic [15:0] wdataB;
    logic [10:0] countB;

    image_loader #(.numPixels(784)) dutA (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .s_valid(s_valid), .s_data(s_data), .s_ready(readyA),
        .wen(wenA), .wadd(waddA), .wdata(wdataA),
        .busy(busyA), .done(doneA), .pix_count(countA)
    );

    image_loader #(.numPixels(5)) dutB (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .s_valid(s_valid), .s_data(s_data), .s_ready(readyB),
        .wen(wenB), .wadd(waddB), .wdata(wdataB),
        .busy(busyB), .done(doneB), .pix_count(countB)
    );

    always #5 clk = ~clk;

    // sel chooses which instance the model follows (0: 784 pixels, 1: 5 pixels)
    bit          sel = 1'b0;
    logic        obsReady, obsWen, obsBusy, obsDone;
    logic [9:0]  obsWadd;
    logic [15:0] obsWdata;
    logic [10:0] obsCount;
    assign obsReady = sel ? readyB : readyA;
    assign obsWen   = sel ? wenB   : wenA;
    assign obsBusy  = sel ? busyB  : busyA;
    assign obsDone  = sel ? doneB  : doneA;
    assign obsWadd  = sel ? waddB  : waddA;
    assign obsWdata = sel ? wdataB : wdataA;
    assign obsCount = sel ? countB : countA;

    int          checks = 0;
    int          fails  = 0;
    logic [15:0] expQ[$];
    int          pushed, expAddr, writes;
    bit          modelBusy, modelDone, lastHs, expReady;
    logic [31:0] lastWord;
    logic [9:0]  holdAddr;
    logic [15:0] holdData;
    logic [31:0] oddWords [4] = '{32'h00010000, 32'h00030002, 32'hBEEF0004, 32'h12345678};
    int          accepted;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            fails++;
            $display("[TB] FAIL %s at %0t: observed %0h expected %0h", tag, $time, got, want);
        end
    endtask

    function automatic int numPix();
        return sel ? 5 : 784;
    endfunction

    function automatic logic [31:0] wordFor(input int i);
        if (sel) return oddWords[(i > 3) ? 3 : i];
        return {16'(2 * i + 1), 16'(2 * i)};
    endfunction

    function automatic void modelReset();
        expQ.delete();
        pushed    = 0;
        expAddr   = 0;
        writes    = 0;
        modelBusy = 1'b0;
        modelDone = 1'b0;
        lastHs    = 1'b0;
        expReady  = 1'b0;
    endfunction

    function automatic void hwReset();
        modelReset();
        holdAddr = '0;
        holdData = '0;
    endfunction

    function automatic void modelStart();
        expQ.delete();
        pushed    = 0;
        expAddr   = 0;
        writes    = 0;
        modelBusy = 1'b1;
        modelDone = 1'b0;
    endfunction

    // Pixels of an accepted word are queued (truncated at the image size) and
    // must leave as one write per cycle starting the cycle after acceptance.
    task automatic monitor();
        logic [15:0] px;
        if (lastHs) begin
            if (pushed < numPix()) begin expQ.push_back(lastWord[15:0]);  pushed++; end
            if (pushed < numPix()) begin expQ.push_back(lastWord[31:16]); pushed++; end
        end
        expReady = modelBusy && (expQ.size() == 0);
        checkOutput("s_ready", 32'(obsReady), 32'(expReady));
        checkOutput("busy", 32'(obsBusy), 32'(modelBusy));
        checkOutput("done", 32'(obsDone), 32'(modelDone));
        checkOutput("pix_count", 32'(obsCount), 32'(expAddr));
        if (expQ.size() != 0) begin
            checkOutput("wen", 32'(obsWen), 32'd1);
            if (obsWen) begin
                px = expQ.pop_front();
                checkOutput("wadd", 32'(obsWadd), 32'(expAddr));
                checkOutput("wdata", 32'(obsWdata), 32'(px));
                holdAddr = 10'(expAddr);
                holdData = px;
                expAddr++;
                writes++;
                if (expAddr == numPix()) begin
                    modelBusy = 1'b0;
                    modelDone = 1'b1;
                end
            end
        end else begin
            checkOutput("wen_idle", 32'(obsWen), 32'd0);
            checkOutput("wadd_hold", 32'(obsWadd), 32'(holdAddr));
            checkOutput("wdata_hold", 32'(obsWdata), 32'(holdData));
        end
    endtask

    task automatic applyStimulus(input bit v, input logic [31:0] d, input bit st, input bit ab);
        @(negedge clk);
        if (rst_n) monitor();
        s_valid  = v;
        s_data   = d;
        start    = st;
        abort    = ab;
        lastHs   = expReady && v && !ab && rst_n;
        lastWord = d;
        if (modelBusy && ab) modelReset();
        else if (!modelBusy && st) modelStart();
    endtask

    task automatic runLoad(input int duty, input int budget, output int acc);
        int wi = 0;
        int c  = 0;
        while (!modelDone && c < budget) begin
            applyStimulus($urandom_range(99) < duty, wordFor(wi), (sel == 1'b0 && c == 50), 1'b0);
            if (lastHs) wi++;
            c++;
        end
        repeat (6) begin
            applyStimulus(1'b1, wordFor(wi), 1'b0, 1'b0);
            if (lastHs) wi++;
        end
        checkOutput("load_done", 32'(obsDone), 32'd1);
        checkOutput("load_count", 32'(obsCount), 32'(numPix()));
        checkOutput("load_writes", 32'(writes), 32'(numPix()));
        acc = wi;
    endtask

    initial begin
        rst_n   = 1'b0;
        start   = 1'b1;
        abort   = 1'b0;
        s_valid = 1'b1;
        s_data  = 32'hFFFF_FFFF;
        hwReset();
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            sel = d[0];
            #1;
            checkOutput("rst_ready", 32'(obsReady), 32'd0);
            checkOutput("rst_wen", 32'(obsWen), 32'd0);
            checkOutput("rst_wadd", 32'(obsWadd), 32'd0);
            checkOutput("rst_wdata", 32'(obsWdata), 32'd0);
            checkOutput("rst_busy", 32'(obsBusy), 32'd0);
            checkOutput("rst_done", 32'(obsDone), 32'd0);
            checkOutput("rst_count", 32'(obsCount), 32'd0);
        end
        sel = 1'b0;
        @(negedge clk);
        rst_n   = 1'b1;
        start   = 1'b0;
        s_valid = 1'b0;

        $display("[TB] full load, s_valid held high");
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
        checkOutput("ready_after_start", 32'(obsReady), 32'd1);
        runLoad(100, 5000, accepted);
        checkOutput("full_words", 32'(accepted), 32'd392);

        $display("[TB] full load, 30%% valid duty");
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        runLoad(30, 12000, accepted);

        $display("[TB] abort with start and handshake in RECV");
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        applyStimulus(1'b1, wordFor(0), 1'b1, 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
        checkOutput("abort_recv_busy", 32'(obsBusy), 32'd0);

        $display("[TB] abort in WR_HI of word 100");
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        accepted = 0;
        for (int c = 0; c < 5000 && accepted <= 100; c++) begin
            applyStimulus(1'b1, wordFor(accepted), 1'b0, 1'b0);
            if (lastHs) accepted++;
        end
        checkOutput("abort_reach", 32'(accepted), 32'd101);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
        checkOutput("abort_wen", 32'(obsWen), 32'd0);
        checkOutput("abort_count", 32'(obsCount), 32'd0);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        runLoad(100, 5000, accepted);

        $display("[TB] async reset during WR_LO");
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        for (int c = 0; c < 20 && !lastHs; c++) applyStimulus(1'b1, wordFor(0), 1'b0, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("arst_wen", 32'(obsWen), 32'd0);
        checkOutput("arst_busy", 32'(obsBusy), 32'd0);
        checkOutput("arst_count", 32'(obsCount), 32'd0);
        hwReset();
        s_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);

        $display("[TB] odd image size of 5 pixels");
        sel = 1'b1;
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        runLoad(100, 200, accepted);
        checkOutput("odd_words", 32'(accepted), 32'd3);
        checkOutput("odd_last_data", 32'(obsWdata), 32'd4);
        checkOutput("odd_last_addr", 32'(obsWadd), 32'd4);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/image_loader.md
Name: image_loader

Overview:
- Write-side feeder for the 28x28 image memory.
- Accepts packed 32-bit words from the SoC over a valid/ready stream and unpacks two 16-bit pixels per word.
- Issues sequential wen/wadd/wdata writes into the image memory write port.
- Reports progress and completion so the CNN controller knows when windowed reads may begin.

Parameters:
numPixels, 784, pixels per image (any value 1..2^addressWidthImg)
addressWidthImg, 10, memory write-address width
dataWidthImg, 16, pixel width; must equal busWidth/2
busWidth, 32, stream word width

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  single-cycle pulse: begin a new image load
abort  in  1  single-cycle pulse: cancel the current load
s_valid  in  1  stream word valid
s_data  in  busWidth  stream word; pixel k in bits [15:0], pixel k+1 in bits [31:16]
s_ready  out  1  loader can accept a word this cycle
wen  out  1  memory write enable
wadd  out  addressWidthImg  memory write address
wdata  out  dataWidthImg  memory write data
busy  out  1  load in progress
done  out  1  image fully written
pix_count  out  addressWidthImg+1  pixels written since the last start

Behaviour:
- Reset (rst_n low, asynchronous):
  - State IDLE.
  - s_ready, wen, busy, done = 0; wadd, wdata, pix_count = 0.
  - Internal word latch = 0.
  - Takes effect immediately, including mid-write: wen drops without waiting for a clock edge.
- States: IDLE, RECV, WR_LO, WR_HI, DONE. All outputs are registered except s_ready, which is 1 only in RECV.
- IDLE:
  - start -> RECV; pix_count cleared to 0; done cleared.
  - abort is ignored in IDLE.
- RECV (busy=1):
  - On the edge where s_valid && s_ready: latch s_data and go to WR_LO.
  - With no handshake, stay in RECV and keep wen=0.
- WR_LO (cycle after accept):
  - wen=1, wadd=pix_count, wdata=word[15:0]; pix_count increments at the end of the cycle.
  - If pix_count+1 == numPixels -> DONE, and the high half is discarded (odd numPixels). Otherwise -> WR_HI.
- WR_HI:
  - wen=1, wadd=pix_count, wdata=word[31:16]; pix_count increments.
  - If pix_count+1 == numPixels -> DONE, else -> RECV.
- DONE:
  - done=1, busy=0, s_ready=0, wen=0. Further stream words are not accepted.
  - start -> RECV with pix_count=0 and done cleared on the same edge.
- Throughput and latency:
  - Peak rate is one word per 3 cycles (RECV, WR_LO, WR_HI). s_ready is never high in back-to-back cycles.
  - First write appears 1 cycle after the accepting edge.
  - done rises on the edge that ends the final write cycle, i.e. 1 cycle after the last write is presented.
- wen outside writes: wen=0 in every cycle that is not WR_LO/WR_HI. wadd and wdata hold their last values when wen=0.
- abort (in RECV, WR_LO or WR_HI):
  - Next state is IDLE, wen=0, busy=0, pix_count=0, done=0.
  - Any pending half-word is dropped.
  - abort wins over a simultaneous handshake: the word is not accepted.
- start while busy is ignored. start and abort together in a busy state: abort wins.
- Address wrap cannot occur: pix_count never exceeds numPixels, and wadd ≤ numPixels-1.
- Pixel data is written unmodified: no offset, sign handling or quantization.

Test Plan:
1. Reset: hold rst_n=0 with s_valid=1 and start=1 -> all outputs 0, no write; release, pulse start -> s_ready=1 next cycle.
2. Full load, default parameters:
   - Stimulus: 392 words, s_valid held 1, word i = {16'(2i+1), 16'(2i)}.
   - Required: exactly 784 writes with wadd=n, wdata=n for n=0..783.
   - Required: done=1 one cycle after the wadd=783 write; pix_count=784; s_ready stays 0 afterwards.
3. Backpressure: s_valid random at 30% duty -> same 784-write sequence, no wen in gaps, wdata never duplicated.
4. Odd size (numPixels=5):
   - Stimulus: words 0x00010000, 0x00030002, 0xBEEF0004.
   - Required: writes 0..4 with data 0..4; 0xBEEF never written; done after the 5th write; a 4th word is not accepted.
5. Abort mid-load:
   - Stimulus: abort in the WR_HI cycle of word 100, then start again.
   - Required: wen=0 next cycle, pix_count=0; the next load's first write is wadd=0.
6. Async reset during WR_LO: drop rst_n between clock edges -> wen=0 and busy=0 before the next rising edge; no further writes.
